// File: rtl/syscall_read.sv
// rtl/syscall_read.sv - read-integer syscall: stalls the CPU until the confirm button, then writes switches to $v0
// Optional debounce filter on enter is built when SYSCALL_READ_DEBOUNCE_EN is defined.
module syscall_read #(
    parameter int          SW_WIDTH        = 16,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] READ_CODE       = 32'd5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                syscall,
    input  logic [31:0]         v0,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic                enter,
    output logic                stall,
    output logic                wb_en,
    output logic [4:0]          wb_addr,
    output logic [31:0]         wb_data,
    output logic [15:0]         read_count
);

    typedef enum logic [1:0] {IDLE, WAIT_REL, WAIT_PRESS, WRITE} state_t;

    state_t              state, state_next;
    logic [SW_WIDTH-1:0] sw_s1, sw_s2;
    logic                en_s1, en_s2;
    logic                db_level, db_prev;
    logic                req, capture;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("syscall_read: DEBOUNCE_CYCLES out of range 2..65535");
    end

    assign req     = syscall && (v0 == READ_CODE);
    assign wb_addr = 5'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            en_s1   <= 1'b0;
            en_s2   <= 1'b0;
            db_prev <= 1'b0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            en_s1   <= enter;
            en_s2   <= en_s1;
            db_prev <= db_level;
        end
    end

`ifdef SYSCALL_READ_DEBOUNCE_EN
    logic        db_q;
    logic [15:0] db_cnt;

    // Level flips only after a full run of disagreeing samples; any bounce restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q   <= 1'b0;
            db_cnt <= '0;
        end else if (en_s2 != db_q) begin
            if (db_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
                db_q   <= en_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign db_level = db_q;
`else
    assign db_level = en_s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wb_data    <= '0;
            read_count <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                wb_data <= 32'($signed(sw_s2));
            end
            if (state == WRITE) begin
                read_count <= read_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        wb_en      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall      = 1'b1;
                    state_next = db_level ? WAIT_REL : WAIT_PRESS;
                end
            end
            // A press already held when the request arrived must be released first.
            WAIT_REL: begin
                stall = 1'b1;
                if (!db_level) begin
                    state_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                stall = 1'b1;
                if (db_level && !db_prev) begin
                    capture    = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wb_en      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_syscall_read.sv
// tb/tb_syscall_read.sv - scoreboard bench for syscall_read
module tb_syscall_read;

    localparam int SETTLE = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic        syscall;
    logic [31:0] v0;
    logic [15:0] sw;
    logic        enter;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [15:0] read_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_count;

    syscall_read dut (
        .clk        (clk),
        .rst        (rst),
        .syscall    (syscall),
        .v0         (v0),
        .sw         (sw),
        .enter      (enter),
        .stall      (stall),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .read_count (read_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            check("wb_addr", 32'(wb_addr), 32'd2);
            check("stall_in_write", 32'(stall), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(wb_en), 32'd0);
            end else begin
                check("wb_data", wb_data, exp_q.pop_front());
            end
        end
    end

    task automatic start_req(input logic [15:0] swv, input logic [31:0] expv);
        sw      = swv;
        v0      = 32'd5;
        syscall = 1'b1;
        exp_q.push_back(expv);
    endtask

    task automatic wait_write(input int hold);
        bit got = 1'b0;
        enter = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == hold) enter = 1'b0;
            if (wb_en === 1'b1) begin
                got = 1'b1;
                break;
            end
            check("stall_waiting", 32'(stall), 32'd1);
        end
        syscall = 1'b0;
        enter   = 1'b0;
        if (!got) check("write_timeout", 32'(got), 32'd1);
        exp_count = exp_count + 16'd1;
        repeat (SETTLE) @(negedge clk);
        check("read_count", 32'(read_count), 32'(exp_count));
        check("stall_after", 32'(stall), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; syscall = 1'b0; v0 = '0; sw = '0; enter = 1'b0;
        exp_count = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_read_count", 32'(read_count), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // negative switch value, sign-extended
        start_req(16'h8001, 32'hFFFF8001);
        #1 check("stall_comb_req", 32'(stall), 32'd1);
        wait_write(20);
        sw = 16'h0000;
        repeat (5) @(negedge clk);
        check("wb_data_hold", wb_data, 32'hFFFF8001);

        // other service codes are ignored
        v0 = 32'd34; syscall = 1'b1; sw = 16'h5555;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            enter = (i >= 5 && i < 25);
            if (i % 8 == 0) check("stall_other_code", 32'(stall), 32'd0);
        end
        syscall = 1'b0; enter = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check("count_other_code", 32'(read_count), 32'(exp_count));

        // press held from before the request must not complete it
        enter = 1'b1;
        repeat (SETTLE) @(negedge clk);
        start_req(16'h1234, 32'h00001234);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i % 10 == 0) check("no_early_write", 32'(wb_en), 32'd0);
        end
        enter = 1'b0;
        for (int i = 0; i < SETTLE; i++) begin
            @(negedge clk);
            if (i % 5 == 0) check("no_write_on_release", 32'(wb_en), 32'd0);
        end
        wait_write(30);

`ifdef SYSCALL_READ_DEBOUNCE_EN
        start_req(16'h00FF, 32'h000000FF);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 3 == 0) enter = ~enter;
            check("no_write_bounce", 32'(wb_en), 32'd0);
        end
        wait_write(40);
`endif

        // reset while waiting for the press aborts the read
        start_req(16'h7777, 32'h00007777);
        repeat (5) @(negedge clk);
        check("stall_wait_press", 32'(stall), 32'd1);
        syscall = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        exp_count = '0;
        #1;
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_wb_en", 32'(wb_en), 32'd0);
        check("abort_count", 32'(read_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        start_req(16'h0042, 32'h00000042);
        wait_write(20);

        // counter wraps from 16'hFFFF to 0
        force dut.read_count = 16'hFFFF;
        @(negedge clk);
        release dut.read_count;
        exp_count = 16'hFFFF;
        @(negedge clk);
        start_req(16'hFFFF, 32'hFFFFFFFF);
        wait_write(20);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/syscall_read.md
SYSCALL_READ -- requirements
Module: syscall_read

Interface
REQ-001 Parameter SW_WIDTH, 16, width of the switch input bank.
REQ-002 Parameter DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a new button level (range 2..65535).
REQ-003 Parameter READ_CODE, 5, $v0 service code for read-integer.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 syscall  input  1  decoded SYSCALL instruction present in the execute stage.
REQ-007 v0  input  32  current $v0 register value.
REQ-008 sw  input  SW_WIDTH  raw board switches, asynchronous to clk.
REQ-009 enter  input  1  raw confirm push-button, asynchronous, active-high.
REQ-010 stall  output  1  high = CPU holds PC and pipeline.
REQ-011 wb_en  output  1  one-cycle register-file write strobe.
REQ-012 wb_addr  output  5  destination register, constant 5'd2 ($v0).
REQ-013 wb_data  output  32  value to write.
REQ-014 read_count  output  16  number of completed reads.

Function
REQ-015 req = syscall && (v0 == READ_CODE); other v0 codes SHALL be ignored by this block.
REQ-016 sw and enter SHALL each pass through a 2-flop synchronizer before any use.
REQ-017 FSM states IDLE, WAIT_REL, WAIT_PRESS, WRITE; encoding free.
REQ-018 IDLE: on req go to WAIT_REL if debounced enter is high, else WAIT_PRESS.
REQ-019 WAIT_REL: go to WAIT_PRESS when debounced enter is low; a press held from before the request SHALL never complete it.
REQ-020 WAIT_PRESS: on debounced enter rising edge, capture synchronized sw into a data register and go to WRITE.
REQ-021 WRITE: wb_en=1 for exactly this cycle, read_count increments (wraps 16'hFFFF->0), next state IDLE unconditionally.
REQ-022 stall = req in IDLE (combinational, same cycle) OR state is WAIT_REL/WAIT_PRESS; stall SHALL be low in WRITE so the PC advances with the writeback.
REQ-023 wb_data = captured switches sign-extended from bit SW_WIDTH-1 to 32 bits; SHALL hold the last captured value when wb_en is low.
REQ-024 Switch changes after capture SHALL not affect wb_data.
REQ-025 Latency: minimum req-to-wb_en = sync (2) + debounce + 1 cycle; no upper bound (waits for user).
REQ-026 req in the WRITE cycle SHALL be ignored; a new request is accepted only from IDLE.
REQ-027 wb_en and stall SHALL never be high in the same cycle.

Reset
REQ-028 rst SHALL immediately force state=IDLE, stall low except via combinational req, wb_en=0, wb_data=0, read_count=0, synchronizers=0, debounced level=0, debounce counter=0.
REQ-029 rst mid-WAIT_PRESS or mid-WRITE SHALL abort with no write issued and no count increment.

Configuration
REQ-030 Macro SYSCALL_READ_DEBOUNCE_EN defined: debounced level changes only after synchronized enter differs from it for DEBOUNCE_CYCLES consecutive cycles; counter clears on any bounce.
REQ-031 Macro undefined: debounce logic removed, debounced level = synchronized enter, DEBOUNCE_CYCLES unused.

Verification
REQ-032 rst released, sw=16'h8001, v0=5, syscall=1, enter pulse held 20 cycles -> stall high until WRITE, one wb_en pulse, wb_addr=2, wb_data=32'hFFFF8001, read_count=1.
REQ-033 v0=34, syscall=1 -> stall=0, wb_en never asserts, read_count unchanged.
REQ-034 enter already high when request arrives, held 50 cycles then released then pressed -> no write before the release; exactly one write after the second press.
REQ-035 (DEBOUNCE_EN, DEBOUNCE_CYCLES=16) enter toggling every 3 cycles for 40 cycles during WAIT_PRESS -> no write; then steady high 16+ cycles -> one write.
REQ-036 rst pulsed 1 cycle while in WAIT_PRESS -> stall drops immediately, no wb_en, read_count=0; new request then completes normally.
REQ-037 read_count preset by 65535 completed reads -> next read wraps read_count to 0.
